// File: rtl/defog_pkg.sv
// Shared types and defaults for the defog atmospheric-light path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the pixel stream is never stalled.
package defog_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACCUM      = 2'd1,
        UPDATE     = 2'd2
    } state_t;

    localparam pix_t A_MIN_DEF  = 8'd100;
    localparam pix_t A_MAX_DEF  = 8'd250;
    localparam pix_t A_INIT_DEF = 8'd230;

    typedef struct packed {
        logic vld;
        pix_t dat;
    } commit_t;

    function automatic pix_t clamp_pix(input pix_t v, input pix_t lo, input pix_t hi);
        pix_t r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/frame_max_tracker.sv
// vsync rising-edge detect and per-frame running maximum of the dark channel.
// Latency: vs_rise is combinational; run_max updates one clk after the pixel.
// Backpressure: none; every qualified pixel is absorbed in the cycle it arrives.
module frame_max_tracker
    import defog_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             vsync,
    input  logic             en,
    input  logic [PIX_W-1:0] dark,
    input  logic             acc_en,
    output logic             vs_rise,
    output logic [PIX_W-1:0] run_max
);

    logic vsync_d;
    pix_t pix_in;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    assign vs_rise = vsync & ~vsync_d;

    // A pixel qualified in the rise cycle opens the new frame; zero clears it otherwise.
    assign pix_in = (acc_en && en) ? dark : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_max <= '0;
        end else if (vs_rise) begin
            run_max <= pix_in;
        end else if (pix_in > run_max) begin
            run_max <= pix_in;
        end
    end

endmodule

// File: rtl/atmos_light_ctrl.sv
// Per-frame atmospheric light A: running max, optional IIR (ATMOS_IIR_EN), clamp.
// Latency: max_of_dark rewritten one clk after the edge that registers the vsync rise.
// Backpressure: none; A is held constant for the whole frame that follows.
module atmos_light_ctrl
    import defog_pkg::*;
#(
    parameter int               SMOOTH_SHIFT = 2,
    parameter logic [PIX_W-1:0] A_MIN        = A_MIN_DEF,
    parameter logic [PIX_W-1:0] A_MAX        = A_MAX_DEF,
    parameter logic [PIX_W-1:0] A_INIT       = A_INIT_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             en,
    input  logic [PIX_W-1:0] dark,
    output logic [PIX_W-1:0] max_of_dark,
    output logic             a_valid,
    output logic             update_pulse,
    output logic [15:0]      frame_cnt
);

    state_t  state;
    state_t  state_nxt;
    logic    vs_rise;
    logic    acc_en;
    pix_t    run_max;
    pix_t    frame_max;
    pix_t    a_raw;
    commit_t commit;

    // hsync is observed only; SMOOTH_SHIFT is inert when smoothing is compiled out.
    logic [32:0] unused_ok;
    assign unused_ok = {hsync, 32'(SMOOTH_SHIFT)};

    frame_max_tracker u_tracker (
        .clk     (clk),
        .nrst    (nrst),
        .vsync   (vsync),
        .en      (en),
        .dark    (dark),
        .acc_en  (acc_en),
        .vs_rise (vs_rise),
        .run_max (run_max)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_FRAME: if (vs_rise) state_nxt = ACCUM;
            ACCUM:      if (vs_rise) state_nxt = UPDATE;
            UPDATE:     state_nxt = vs_rise ? UPDATE : ACCUM;
            default:    state_nxt = WAIT_FRAME;
        endcase
    end

`ifdef ATMOS_IIR_EN
    localparam int SUM_W = PIX_W + SMOOTH_SHIFT + 1;

    logic [SUM_W-1:0] iir_sum;
    logic             unused_iir_msb;

    assign iir_sum        = SUM_W'(max_of_dark) * SUM_W'((1 << SMOOTH_SHIFT) - 1)
                          + SUM_W'(frame_max);
    assign unused_iir_msb = iir_sum[SUM_W-1];
    // The first commit seeds the filter directly so A does not crawl from A_INIT.
    assign a_raw          = a_valid ? iir_sum[SMOOTH_SHIFT +: PIX_W] : frame_max;
`else
    assign a_raw = frame_max;
`endif

    always_comb begin
        acc_en     = (state != WAIT_FRAME);
        commit     = '0;
        commit.vld = (state == UPDATE) && (frame_max != '0);
        commit.dat = clamp_pix(a_raw, A_MIN, A_MAX);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_max <= '0;
            frame_cnt <= '0;
        end else if (vs_rise) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (state != WAIT_FRAME) begin
                frame_max <= run_max;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            max_of_dark  <= A_INIT;
            a_valid      <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= commit.vld;
            if (commit.vld) begin
                max_of_dark <= commit.dat;
                a_valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atmos_light_ctrl.sv
// Randomized frame streams against a frame-level reference model of atmospheric light.
module tb_atmos_light_ctrl;

    localparam int K = 2;
`ifdef ATMOS_IIR_EN
    localparam bit IIR = 1'b1;
`else
    localparam bit IIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        hsync;
    logic        vsync;
    logic        en;
    logic [7:0]  dark;
    logic [7:0]  max_of_dark;
    logic        a_valid;
    logic        update_pulse;
    logic [15:0] frame_cnt;

    atmos_light_ctrl #(.SMOOTH_SHIFT(K)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .hsync        (hsync),
        .vsync        (vsync),
        .en           (en),
        .dark         (dark),
        .max_of_dark  (max_of_dark),
        .a_valid      (a_valid),
        .update_pulse (update_pulse),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         vs;
        bit         e;
        logic [7:0] d;
    } stim_t;

    stim_t q[$];
    int    vec = 0;
    int    err = 0;

    // Reference model: frame bookkeeping plus a one-cycle-deferred commit.
    bit m_prev_vs, m_in_frame, m_pend, m_valid, m_pulse;
    int m_cur, m_pend_fm, m_a, m_cnt;

    function automatic int exp_a(input int a_old, input int fm, input bit valid);
        int v;
        v = (valid && IIR) ? (a_old * ((1 << K) - 1) + fm) >> K : fm;
        if (v < 100) v = 100;
        if (v > 250) v = 250;
        return v;
    endfunction

    task automatic model_reset;
        m_prev_vs = 0; m_in_frame = 0; m_pend = 0; m_valid = 0; m_pulse = 0;
        m_cur = 0; m_pend_fm = 0; m_a = 230; m_cnt = 0;
    endtask

    task automatic model_step(input bit vs, input bit e, input int d);
        bit rise;
        rise      = vs && !m_prev_vs;
        m_prev_vs = vs;
        m_pulse   = 0;
        if (m_pend && m_pend_fm != 0) begin
            m_a     = exp_a(m_a, m_pend_fm, m_valid);
            m_valid = 1;
            m_pulse = 1;
        end
        m_pend = 0;
        if (rise) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (m_in_frame) begin
                m_pend    = 1;
                m_pend_fm = m_cur;
                m_cur     = e ? d : 0;
            end else begin
                m_in_frame = 1;
                m_cur      = 0;
            end
        end else if (m_in_frame && e && d > m_cur) begin
            m_cur = d;
        end
    endtask

    task automatic tick(input stim_t s);
        @(negedge clk);
        vsync = s.vs;
        en    = s.e;
        dark  = s.d;
        hsync = 1'($urandom);
        model_step(s.vs, s.e, int'(s.d));
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit vs, input bit e, input int d);
        stim_t s;
        s.vs = vs;
        s.e  = e;
        s.d  = 8'(d);
        q.push_back(s);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(0, 0, 0);
    endtask

    // n random pixels <= maxd, then the peak pixel pk, then a vsync rise.
    task automatic push_frame(input int n, input int maxd, input int pk, input bit en_on,
                              input bit rise_e, input int rise_d);
        for (int i = 0; i < n; i++)
            push(0, en_on ? 1'($urandom) : 1'b0, int'($urandom_range(0, maxd)));
        if (en_on) push(0, 1, pk);
        push(1, rise_e, rise_d);
    endtask

    task automatic do_reset;
        @(negedge clk);
        nrst = 0; vsync = 0; en = 0; dark = 0;
        model_reset();
        @(negedge clk);
        nrst = 1;
        q.delete();
    endtask

    task automatic test_reset;
        nrst = 0;
        model_reset();
        @(posedge clk);
        #1;
        vec++;
        if (max_of_dark !== 8'd230 || a_valid !== 1'b0 || update_pulse !== 1'b0 || frame_cnt !== 16'd0) begin
            err++;
            $display("FAIL reset: got A=%0d v=%0b p=%0b cnt=%0d want A=230 v=0 p=0 cnt=0",
                     max_of_dark, a_valid, update_pulse, frame_cnt);
        end
        @(negedge clk);
        nrst = 1;
        q.delete();
        push_idle(4);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL reset_idle cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
    endtask

    task automatic test_first_frame;
        do_reset();
        push(1, 0, 0);
        push_idle(1);
        push_frame(12, 179, 180, 1, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL first_frame cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (max_of_dark !== 8'd180 || a_valid !== 1'b1 || frame_cnt !== 16'd2) begin
            err++;
            $display("FAIL first_frame_final: got A=%0d v=%0b cnt=%0d want A=180 v=1 cnt=2",
                     max_of_dark, a_valid, frame_cnt);
        end
    endtask

    task automatic test_iir;
        do_reset();
        push(1, 0, 0);
        push_frame(10, 199, 200, 1, 0, 0);
        push_idle(2);
        push_frame(10, 239, 240, 1, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL iir cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (max_of_dark !== (IIR ? 8'd210 : 8'd240)) begin
            err++;
            $display("FAIL iir_final: got A=%0d want %0d", max_of_dark, IIR ? 210 : 240);
        end
    endtask

    task automatic test_clamp;
        do_reset();
        push(1, 0, 0);
        push_frame(8, 254, 255, 1, 0, 0);
        push_idle(2);
        foreach (q[i]) tick(q[i]);
        vec++;
        if (max_of_dark !== 8'd250) begin
            err++;
            $display("FAIL clamp_max: got A=%0d want 250", max_of_dark);
        end
        q.delete();
        push_frame(8, 19, 20, 1, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL clamp_iir cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (max_of_dark !== (IIR ? 8'd192 : 8'd100)) begin
            err++;
            $display("FAIL clamp_low_frame: got A=%0d want %0d", max_of_dark, IIR ? 192 : 100);
        end
        do_reset();
        push(1, 0, 0);
        push_frame(8, 39, 40, 1, 0, 0);
        push_idle(2);
        foreach (q[i]) tick(q[i]);
        vec++;
        if (max_of_dark !== 8'd100 || a_valid !== 1'b1) begin
            err++;
            $display("FAIL clamp_min: got A=%0d v=%0b want A=100 v=1", max_of_dark, a_valid);
        end
    endtask

    task automatic test_empty;
        do_reset();
        push(1, 0, 0);
        push_frame(6, 149, 150, 1, 0, 0);
        push_idle(2);
        push_frame(10, 255, 0, 0, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL empty cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (max_of_dark !== 8'd150 || frame_cnt !== 16'd3) begin
            err++;
            $display("FAIL empty_final: got A=%0d cnt=%0d want A=150 cnt=3", max_of_dark, frame_cnt);
        end
    endtask

    task automatic test_rise_pixel;
        do_reset();
        push(1, 0, 0);
        push_frame(8, 149, 150, 1, 1, 199);
        push_idle(2);
        push_frame(8, 119, 120, 1, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL rise_pixel cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (max_of_dark !== (IIR ? 8'd162 : 8'd199)) begin
            err++;
            $display("FAIL rise_pixel_final: got A=%0d want %0d", max_of_dark, IIR ? 162 : 199);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        push(1, 0, 0);
        for (int i = 0; i < 5; i++) push(0, 1, 200);
        push(0, 1, 30);
        foreach (q[i]) tick(q[i]);
        #2;
        nrst = 0;
        #1;
        vec++;
        if (max_of_dark !== 8'd230 || a_valid !== 1'b0 || update_pulse !== 1'b0 || frame_cnt !== 16'd0) begin
            err++;
            $display("FAIL async_reset: got A=%0d v=%0b p=%0b cnt=%0d want A=230 v=0 p=0 cnt=0",
                     max_of_dark, a_valid, update_pulse, frame_cnt);
        end
        vsync = 0; en = 0; dark = 0;
        model_reset();
        @(negedge clk);
        nrst = 1;
        q.delete();
        push(1, 0, 0);
        push_frame(6, 159, 160, 1, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL async_after cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (max_of_dark !== 8'd160) begin
            err++;
            $display("FAIL async_after_final: got A=%0d want 160", max_of_dark);
        end
    endtask

    task automatic test_vsync_held;
        do_reset();
        push(1, 0, 0);
        push_frame(6, 200, 201, 1, 0, 0);
        for (int i = 0; i < 12; i++) push(1, 1'($urandom), int'($urandom_range(0, 255)));
        push_frame(6, 180, 181, 1, 0, 0);
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL vsync_held cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (frame_cnt !== 16'd3) begin
            err++;
            $display("FAIL vsync_held_cnt: got cnt=%0d want 3", frame_cnt);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 24; i++) push(i % 2 == 0, 1'($urandom), int'($urandom_range(0, 255)));
        push_idle(3);
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL back_to_back cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
        vec++;
        if (frame_cnt !== 16'd12) begin
            err++;
            $display("FAIL back_to_back_cnt: got cnt=%0d want 12", frame_cnt);
        end
    endtask

    task automatic test_random;
        bit vs;
        vs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) vs = ~vs;
            push(vs, 1'($urandom), int'($urandom_range(0, 255)));
        end
        foreach (q[i]) begin
            tick(q[i]);
            vec++;
            if ({max_of_dark, a_valid, update_pulse, frame_cnt} !== {8'(m_a), m_valid, m_pulse, 16'(m_cnt)}) begin
                err++;
                $display("FAIL random cyc %0d: got A=%0d v=%0b p=%0b cnt=%0d want A=%0d v=%0b p=%0b cnt=%0d",
                         i, max_of_dark, a_valid, update_pulse, frame_cnt, m_a, m_valid, m_pulse, m_cnt);
            end
        end
    endtask

    initial begin
        nrst  = 0;
        hsync = 0;
        vsync = 0;
        en    = 0;
        dark  = 0;
        model_reset();
        test_reset();
        test_first_frame();
        test_iir();
        test_clamp();
        test_empty();
        test_rise_pixel();
        test_async_reset();
        test_vsync_held();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
